// File: rtl/echo_delay_meter_pkg.sv
// Shared types and constants for the loopback round-trip delay meter.
package echo_delay_meter_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      WAIT_RISE,
      WAIT_FALL,
      DONE
   } state_t;

   localparam int SYNC_LAT = 2;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit flop-chain synchronizer for the asynchronous echo pad input.
module sync_2ff
   import echo_delay_meter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_LAT-1:0] stage_reg;
   logic [SYNC_LAT-1:0] stage_next;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_LAT; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            assign stage_next[gi] = d;
         end else begin : g_chain
            assign stage_next[gi] = stage_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         stage_reg <= '0;
      end else begin
         stage_reg <= stage_next;
      end
   end

   assign q = stage_reg[SYNC_LAT-1];

endmodule

// File: rtl/echo_delay_meter.sv
// Fires probe edges, counts cycles until each returns, and reports the
// average over 2^LOG_RUNS runs (or all-ones with timeout set on abort).
module echo_delay_meter
   import echo_delay_meter_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int TIMEOUT  = 1000,
   parameter int LOG_RUNS = 2
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             echo_in,
   output logic             probe_out,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] result
);

   localparam int RUN_W = (LOG_RUNS > 0) ? LOG_RUNS : 1;
   localparam int ACC_W = CNT_W + LOG_RUNS;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);
   localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'((1 << LOG_RUNS) - 1);

   logic echo_s;

   state_t             state_reg,   state_next;
   logic [CNT_W-1:0]   cnt_reg,     cnt_next;
   logic [ACC_W-1:0]   acc_reg,     acc_next;
   logic [RUN_W-1:0]   run_reg,     run_next;
   logic               probe_reg,   probe_next;
   logic               busy_reg,    busy_next;
   logic               done_reg,    done_next;
   logic               timeout_reg, timeout_next;
   logic [CNT_W-1:0]   result_reg,  result_next;
   logic               cnt_hit;
   logic               abort;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (echo_in),
      .q   (echo_s)
   );

   assign cnt_hit = (cnt_reg == CNT_LIMIT);

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      acc_next     = acc_reg;
      run_next     = run_reg;
      probe_next   = probe_reg;
      timeout_next = timeout_reg;
      result_next  = result_reg;
      abort        = 1'b0;

      case (state_reg)
         IDLE: begin
            probe_next = 1'b0;
            if (start) begin
               acc_next     = '0;
               run_next     = '0;
               cnt_next     = '0;
               timeout_next = 1'b0;
               state_next   = ARM;
            end
         end
         ARM: begin
            if (!echo_s) begin
               probe_next = 1'b1;
               cnt_next   = '0;
               state_next = WAIT_RISE;
            end else if (cnt_hit) begin
               abort = 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         WAIT_RISE: begin
            if (echo_s) begin
               acc_next   = acc_reg + ACC_W'(cnt_reg);
               probe_next = 1'b0;
               cnt_next   = '0;
               state_next = WAIT_FALL;
            end else if (cnt_hit) begin
               abort = 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         WAIT_FALL: begin
            if (!echo_s) begin
               cnt_next = '0;
               if (run_reg == RUN_LAST) begin
                  // Result is latched on entry so it appears together with done.
                  result_next = CNT_W'(acc_reg >> LOG_RUNS);
                  state_next  = DONE;
               end else begin
                  run_next   = run_reg + 1'b1;
                  state_next = ARM;
               end
            end else if (cnt_hit) begin
               abort = 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (abort) begin
         timeout_next = 1'b1;
         result_next  = '1;
         probe_next   = 1'b0;
         state_next   = DONE;
      end

      done_next = (state_next == DONE);
      busy_next = (state_next != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         acc_reg     <= '0;
         run_reg     <= '0;
         probe_reg   <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         timeout_reg <= 1'b0;
         result_reg  <= '0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         acc_reg     <= acc_next;
         run_reg     <= run_next;
         probe_reg   <= probe_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         timeout_reg <= timeout_next;
         result_reg  <= result_next;
      end
   end

   assign probe_out = probe_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;
   assign timeout   = timeout_reg;
   assign result    = result_reg;

endmodule
